sram_1rw1r_model: RTL and testbench
===================================

// Module: sram_1rw1r_model
// PURPOSE
//  Parametrised, synthesisable 1RW+1R SRAM: one read/write port (p0) and one read-only port (p1) on a single clock.
//  Port semantics match the 32x256 sky130 macro pins (csb/web active-low, byte write mask).
//  Adds options the fixed macro lacks: configurable width/depth, selectable read latency, p0->p1 write bypass,
//  and a clear-on-reset sequencer. Used wherever a non-macro or non-32x256 RAM is needed (sim, FPGA, small buffers).
// PARAMETERS
//  DATA_W      32   data width in bits; must be a multiple of 8
//  DEPTH       256  number of words; need not be a power of 2
//  RD_LAT      1    read latency in cycles, 1 or 2 (2 adds an output register stage)
//  BYPASS      1    1: p1 read of the address p0 writes in the same cycle returns the new data; 0: returns old data
//  CLR_ON_RST  1    1: zero every word after reset, with init_busy_o high; 0: memory contents undefined, no clear
//  (derived) ADDR_W = $clog2(DEPTH), MASK_W = DATA_W/8
// PORTS
//  clk_i        in   1       single clock for both ports
//  rst_i        in   1       synchronous, active-high reset
//  init_busy_o  out  1       clear sequence in progress; requests ignored while high
//  p0_csb_i     in   1       port 0 chip select, active low
//  p0_web_i     in   1       port 0 write enable, active low (0=write, 1=read)
//  p0_wmask_i   in   MASK_W  byte write mask, bit i enables din[8i+7:8i]
//  p0_addr_i    in   ADDR_W  port 0 word address
//  p0_din_i     in   DATA_W  port 0 write data
//  p0_dout_o    out  DATA_W  port 0 read data
//  p0_dvalid_o  out  1       one-cycle pulse: p0_dout_o carries the result of a p0 read
//  p1_csb_i     in   1       port 1 chip select, active low (read only)
//  p1_addr_i    in   ADDR_W  port 1 word address
//  p1_dout_o    out  DATA_W  port 1 read data
//  p1_dvalid_o  out  1       one-cycle pulse: p1_dout_o carries the result of a p1 read
// BEHAVIOUR
//  Reset, while rst_i=1: p*_dout_o=0; p*_dvalid_o=0; all pipeline registers cleared; init_busy_o=CLR_ON_RST.
//  Init FSM states: CLEAR, READY.
//   - CLR_ON_RST=1: rst_i puts the FSM in CLEAR with clr_addr=0. Each cycle writes 0 to clr_addr and increments it.
//     After the DEPTH-1 write, the FSM goes to READY, and init_busy_o drops on that edge (DEPTH cycles of busy).
//   - CLR_ON_RST=0: the FSM is in READY in the first cycle after reset and init_busy_o=0.
//   - rst_i asserted mid-CLEAR restarts the clear at address 0.
//  Requests are accepted only in READY. In CLEAR, csb is ignored, no dvalid is produced and no user write happens.
//  p0 write, when csb=0 and web=0: at the clock edge, only bytes with wmask=1 are updated.
//   - A write with wmask=0 is a no-op.
//   - A write produces no dvalid; p0_dout_o holds its previous value.
//  p0 read, when csb=0 and web=1: mem[addr] is sampled at the edge. p0_dout_o and p0_dvalid_o appear RD_LAT cycles after acceptance.
//  p1 read: same rule as a p0 read, on the p1 pins.
//  Outputs hold their last read value between reads; dvalid is high only in the result cycle.
//  Back-to-back reads give one result per cycle (fully pipelined).
//  Collision, p1 read and p0 write to the same address in the same cycle:
//   - BYPASS=1: p1 result = new data on masked bytes, old data on unmasked bytes.
//   - BYPASS=0: p1 result = pre-write contents.
//  A p0 and p1 read of the same address in the same cycle both return identical data.
//  Out-of-range address (addr >= DEPTH, non-power-of-2 DEPTH only):
//   - a write is dropped;
//   - a read still pulses dvalid and returns 0.
//  A read issued on the cycle a prior write landed sees the written data (write-then-read ordering across cycles).
// TESTING
//  1. CLR_ON_RST=1, DEPTH=256: release rst -> init_busy_o high exactly 256 cycles; then a read of each address returns 0.
//  2. RD_LAT=1: write 0xDEADBEEF to addr 5 with mask 4'hF, next cycle p0 read addr 5 -> 0xDEADBEEF one cycle later with p0_dvalid_o=1.
//     RD_LAT=2 -> the same result two cycles later.
//  3. Byte mask: addr 7 holds 0x11223344; write 0xAABBCCDD with mask 4'b0101 -> a read returns 0x11BB33DD.
//  4. Collision: addr 9=0x0; same cycle p0 writes 0x12345678 (mask F) and p1 reads addr 9.
//     BYPASS=1 -> p1_dout_o=0x12345678; BYPASS=0 -> 0x00000000.
//  5. Assert rst_i at clear cycle 100 -> outputs zero; clear restarts, and init_busy_o drops 256 cycles after release.
//  6. DEPTH=200: write addr 210 is dropped, and a read of addr 210 returns 0 with dvalid. Back-to-back p1 reads of addrs 0..9 -> 10 consecutive dvalid pulses, in order.

Source files
------------

// File: rtl/sram_1rw1r_model.sv
// Parametrised 1RW+1R SRAM with macro-style pins, selectable read latency,
// optional p0->p1 write bypass and a clear-after-reset sequencer.
module sram_1rw1r_model #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned CLR_ON_RST = 1,
  localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned MASK_W    = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_busy_o,
  input  logic              p0_csb_i,
  input  logic              p0_web_i,
  input  logic [MASK_W-1:0] p0_wmask_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_din_i,
  output logic [DATA_W-1:0] p0_dout_o,
  output logic              p0_dvalid_o,
  input  logic              p1_csb_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  output logic [DATA_W-1:0] p1_dout_o,
  output logic              p1_dvalid_o
);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                busy_q;
  logic                clr_we_c;
  logic                ready_c;
  logic                p0_in_range_c, p1_in_range_c;
  logic                p0_wr_c, p0_rd_c, p1_rd_c;
  logic [DATA_W-1:0]   p0_rdata_c, p1_rdata_c;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   s1_p0_data_q, s1_p1_data_q;
  logic                s1_p0_vld_q, s1_p1_vld_q;

  // Init sequencer: walk every address once, then open the ports.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we_c   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_c   = ~rst_i;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = ST_READY;
          clr_addr_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
      busy_q     <= (CLR_ON_RST != 0);
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= (state_d == ST_CLEAR);
    end
  end

  assign init_busy_o   = busy_q;
  assign ready_c       = (state_q == ST_READY) && !rst_i;
  assign p0_in_range_c = 32'(p0_addr_i) < DEPTH;
  assign p1_in_range_c = 32'(p1_addr_i) < DEPTH;
  assign p0_wr_c       = ready_c && !p0_csb_i && !p0_web_i && p0_in_range_c;
  assign p0_rd_c       = ready_c && !p0_csb_i && p0_web_i;
  assign p1_rd_c       = ready_c && !p1_csb_i;

  // Read muxes; out-of-range reads return zero, p1 optionally sees p0's write.
  always_comb begin
    p0_rdata_c = p0_in_range_c ? mem_q[p0_addr_i] : '0;
    p1_rdata_c = p1_in_range_c ? mem_q[p1_addr_i] : '0;
    if ((BYPASS != 0) && p0_wr_c && (p1_addr_i == p0_addr_i)) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (p0_wmask_i[b]) p1_rdata_c[8*b +: 8] = p0_din_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_we_c) begin
      mem_q[clr_addr_q] <= '0;
    end else if (p0_wr_c) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (p0_wmask_i[b]) mem_q[p0_addr_i][8*b +: 8] <= p0_din_i[8*b +: 8];
      end
    end
  end

  // First read stage: data registers only load on an accepted read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_p0_data_q <= '0;
      s1_p1_data_q <= '0;
      s1_p0_vld_q  <= 1'b0;
      s1_p1_vld_q  <= 1'b0;
    end else begin
      s1_p0_vld_q <= p0_rd_c;
      s1_p1_vld_q <= p1_rd_c;
      if (p0_rd_c) s1_p0_data_q <= p0_rdata_c;
      if (p1_rd_c) s1_p1_data_q <= p1_rdata_c;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s2_p0_data_q, s2_p1_data_q;
      logic              s2_p0_vld_q, s2_p1_vld_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2_p0_data_q <= '0;
          s2_p1_data_q <= '0;
          s2_p0_vld_q  <= 1'b0;
          s2_p1_vld_q  <= 1'b0;
        end else begin
          s2_p0_vld_q <= s1_p0_vld_q;
          s2_p1_vld_q <= s1_p1_vld_q;
          if (s1_p0_vld_q) s2_p0_data_q <= s1_p0_data_q;
          if (s1_p1_vld_q) s2_p1_data_q <= s1_p1_data_q;
        end
      end

      assign p0_dout_o   = s2_p0_data_q;
      assign p0_dvalid_o = s2_p0_vld_q;
      assign p1_dout_o   = s2_p1_data_q;
      assign p1_dvalid_o = s2_p1_vld_q;
    end else begin : g_lat1
      assign p0_dout_o   = s1_p0_data_q;
      assign p0_dvalid_o = s1_p0_vld_q;
      assign p1_dout_o   = s1_p1_data_q;
      assign p1_dvalid_o = s1_p1_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// Bench for sram_1rw1r_model: two configurations driven by the same pins,
// results checked through per-port scoreboard queues with latency tags.
module tb_sram_1rw1r_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_csb, p0_web, p1_csb;
  logic [3:0]  p0_wmask;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_din;

  logic        a_busy, a_v0, a_v1, b_busy, b_v0, b_v1;
  logic [31:0] a_d0, a_d1, b_d0, b_d1;

  always #5 clk = ~clk;

  // A: 256 deep, latency 1, bypass on.  B: 200 deep, latency 2, bypass off.
  sram_1rw1r_model dut_a (
    .clk_i(clk), .rst_i(rst), .init_busy_o(a_busy),
    .p0_csb_i(p0_csb), .p0_web_i(p0_web), .p0_wmask_i(p0_wmask),
    .p0_addr_i(p0_addr), .p0_din_i(p0_din), .p0_dout_o(a_d0), .p0_dvalid_o(a_v0),
    .p1_csb_i(p1_csb), .p1_addr_i(p1_addr), .p1_dout_o(a_d1), .p1_dvalid_o(a_v1)
  );

  sram_1rw1r_model #(.DEPTH(200), .RD_LAT(2), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .init_busy_o(b_busy),
    .p0_csb_i(p0_csb), .p0_web_i(p0_web), .p0_wmask_i(p0_wmask),
    .p0_addr_i(p0_addr), .p0_din_i(p0_din), .p0_dout_o(b_d0), .p0_dvalid_o(b_v0),
    .p1_csb_i(p1_csb), .p1_addr_i(p1_addr), .p1_dout_o(b_d1), .p1_dvalid_o(b_v1)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        p0_en;
    logic        p0_wr;
    logic [3:0]  mask;
    logic [7:0]  a0;
    logic [31:0] din;
    logic        p1_en;
    logic [7:0]  a1;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [31:0] eb0;
    logic [31:0] eb1;
  } vec_t;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic spurious(input string name);
    total++;
    bad++;
    $display("FAIL %s: dvalid with no outstanding read (cycle %0d)", name, cyc);
  endtask

  // Drive one vector and queue the results each configuration must produce.
  task automatic apply(input vec_t v);
    p0_csb   = ~v.p0_en;
    p0_web   = ~v.p0_wr;
    p0_wmask = v.mask;
    p0_addr  = v.a0;
    p0_din   = v.din;
    p1_csb   = ~v.p1_en;
    p1_addr  = v.a1;
    if (v.p0_en && !v.p0_wr) begin
      qa0.push_back('{v.ea0, cyc + 1});
      qb0.push_back('{v.eb0, cyc + 2});
    end
    if (v.p1_en) begin
      qa1.push_back('{v.ea1, cyc + 1});
      qb1.push_back('{v.eb1, cyc + 2});
    end
  endtask

  task automatic idle();
    p0_csb = 1'b1;
    p1_csb = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_v0) begin
      if (qa0.size() == 0) spurious("a_p0");
      else begin
        e = qa0.pop_front();
        check("a_p0 data", a_d0, e.data);
        check("a_p0 latency", 32'(cyc), 32'(e.due));
      end
    end
    if (a_v1) begin
      if (qa1.size() == 0) spurious("a_p1");
      else begin
        e = qa1.pop_front();
        check("a_p1 data", a_d1, e.data);
        check("a_p1 latency", 32'(cyc), 32'(e.due));
      end
    end
    if (b_v0) begin
      if (qb0.size() == 0) spurious("b_p0");
      else begin
        e = qb0.pop_front();
        check("b_p0 data", b_d0, e.data);
        check("b_p0 latency", 32'(cyc), 32'(e.due));
      end
    end
    if (b_v1) begin
      if (qb1.size() == 0) spurious("b_p1");
      else begin
        e = qb1.pop_front();
        check("b_p1 data", b_d1, e.data);
        check("b_p1 latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  vec_t tbl[15];

  initial begin
    int cnt_a, cnt_b, wait_n;

    //          p0en  p0wr  mask     a0      din            p1en  a1      ea0            ea1            eb0            eb1
    tbl[0]  = '{1'b1, 1'b1, 4'hF,    8'd5,   32'hDEADBEEF,  1'b0, 8'd0,   32'h0,         32'h0,         32'h0,         32'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h0,    8'd5,   32'h0,         1'b0, 8'd0,   32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h0};
    tbl[2]  = '{1'b1, 1'b1, 4'hF,    8'd7,   32'h11223344,  1'b0, 8'd0,   32'h0,         32'h0,         32'h0,         32'h0};
    tbl[3]  = '{1'b1, 1'b1, 4'b0101, 8'd7,   32'hAABBCCDD,  1'b0, 8'd0,   32'h0,         32'h0,         32'h0,         32'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'h0,    8'd7,   32'h0,         1'b0, 8'd0,   32'h11BB33DD,  32'h0,         32'h11BB33DD,  32'h0};
    tbl[5]  = '{1'b1, 1'b1, 4'hF,    8'd9,   32'h12345678,  1'b1, 8'd9,   32'h0,         32'h12345678,  32'h0,         32'h00000000};
    tbl[6]  = '{1'b1, 1'b0, 4'h0,    8'd5,   32'h0,         1'b1, 8'd9,   32'hDEADBEEF,  32'h12345678,  32'hDEADBEEF,  32'h12345678};
    tbl[7]  = '{1'b1, 1'b1, 4'hF,    8'd210, 32'hCAFEF00D,  1'b0, 8'd0,   32'h0,         32'h0,         32'h0,         32'h0};
    tbl[8]  = '{1'b1, 1'b0, 4'h0,    8'd210, 32'h0,         1'b1, 8'd210, 32'hCAFEF00D,  32'hCAFEF00D,  32'h0,         32'h0};
    tbl[9]  = '{1'b1, 1'b1, 4'h0,    8'd11,  32'hFFFFFFFF,  1'b0, 8'd0,   32'h0,         32'h0,         32'h0,         32'h0};
    tbl[10] = '{1'b1, 1'b0, 4'h0,    8'd11,  32'h0,         1'b1, 8'd7,   32'h0,         32'h11BB33DD,  32'h0,         32'h11BB33DD};
    tbl[11] = '{1'b1, 1'b0, 4'h0,    8'd9,   32'h0,         1'b1, 8'd9,   32'h12345678,  32'h12345678,  32'h12345678,  32'h12345678};
    tbl[12] = '{1'b1, 1'b1, 4'b1000, 8'd12,  32'hA5A5A5A5,  1'b1, 8'd12,  32'h0,         32'hA5000000,  32'h0,         32'h0};
    tbl[13] = '{1'b0, 1'b1, 4'hF,    8'd5,   32'h0,         1'b1, 8'd5,   32'h0,         32'hDEADBEEF,  32'h0,         32'hDEADBEEF};
    tbl[14] = '{1'b1, 1'b0, 4'h0,    8'd12,  32'h0,         1'b1, 8'd12,  32'hA5000000,  32'hA5000000,  32'hA5000000,  32'hA5000000};

    rst = 1'b1; p0_web = 1'b1; p0_wmask = 4'h0; p0_addr = 8'd0; p0_din = 32'h0; p1_addr = 8'd0;
    idle();
    repeat (3) @(negedge clk);
    check("reset a_p0 dout", a_d0, 32'h0);
    check("reset a_p1 dout", a_d1, 32'h0);
    check("reset a dvalid", 32'({a_v0, a_v1}), 32'h0);
    check("reset a busy", 32'(a_busy), 32'h1);
    check("reset b busy", 32'(b_busy), 32'h1);

    // First clear, then leave non-zero data and a non-zero p0 output behind.
    rst = 1'b0;
    wait_n = 0;
    while ((a_busy || b_busy) && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("first clear finishes", 32'(a_busy || b_busy), 32'h0);
    @(negedge clk) apply('{1'b1, 1'b1, 4'hF, 8'd0, 32'h11111111, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0});
    @(negedge clk) apply('{1'b1, 1'b1, 4'hF, 8'd150, 32'h22222222, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0});
    @(negedge clk) apply('{1'b1, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd150, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222});
    @(negedge clk) idle();
    repeat (4) @(negedge clk);

    // Reset, then reset again 100 cycles into the clear.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("mid-clear a busy", 32'(a_busy), 32'h1);
    check("mid-clear b busy", 32'(b_busy), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid-clear rst a_p0 dout", a_d0, 32'h0);
    check("mid-clear rst b_p1 dout", b_d1, 32'h0);
    check("mid-clear rst busy", 32'({a_busy, b_busy}), 32'h3);

    // Count busy cycles from release; requests during the clear must be ignored.
    rst = 1'b0;
    p0_csb = 1'b0; p0_web = 1'b0; p0_wmask = 4'hF; p0_addr = 8'd20; p0_din = 32'hFFFFFFFF;
    p1_csb = 1'b0; p1_addr = 8'd3;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 400 && (a_busy || b_busy); i++) begin
      if (i == 150) idle();
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      @(negedge clk);
    end
    idle();
    check("a busy cycles", 32'(cnt_a), 32'd256);
    check("b busy cycles", 32'(cnt_b), 32'd200);

    // Every word reads zero; back-to-back on both ports, B past 199 is out of range.
    for (int i = 0; i < 256; i++) begin
      apply('{1'b1, 1'b0, 4'h0, 8'(255 - i), 32'h0, 1'b1, 8'(i), 32'h0, 32'h0, 32'h0, 32'h0});
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      @(negedge clk);
    end
    idle();
    repeat (5) @(negedge clk);

    check("a_p0 hold after writes", a_d0, 32'hA5000000);
    check("b_p0 hold after writes", b_d0, 32'hA5000000);
    check("a_p0 dvalid idle", 32'(a_v0), 32'h0);
    check("qa0 drained", 32'(qa0.size()), 32'h0);
    check("qa1 drained", 32'(qa1.size()), 32'h0);
    check("qb0 drained", 32'(qb0.size()), 32'h0);
    check("qb1 drained", 32'(qb1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
